// File: rtl/bus_transfer_ctrl_if.sv
// Request / strobe / bus bundle between the CPU decode logic, bus_transfer_ctrl
// and the bus register bank.
// slave  : the transfer controller's view.
// master : the environment's view (request source plus the register bus).
interface bus_transfer_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_src;
  logic [SEL_W-1:0]    req_dst;
  logic [NUM_REGS-1:0] enable_out;
  logic [NUM_REGS-1:0] load_out;
  logic [DATA_W-1:0]   bus_in;
  logic [DATA_W-1:0]   xfer_data;
  logic                done;
  logic                err;
  logic                busy;

  modport slave (
    input  req_valid, req_src, req_dst, bus_in,
    output req_ready, enable_out, load_out, xfer_data, done, err, busy
  );

  modport master (
    output req_valid, req_src, req_dst, bus_in,
    input  req_ready, enable_out, load_out, xfer_data, done, err, busy
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: queues register-to-register moves and sequences each one
// as a DRIVE cycle (source enable) followed by a LOAD cycle (destination
// load_enable). Back-to-back moves run at one transfer per 2 cycles.
// Optional feature: define XFER_COUNT_EN to add an 8-bit completed-transfer
// counter on port xfer_count.
module bus_transfer_ctrl #(
  parameter int NUM_REGS   = 4,
  parameter int SEL_W      = 2,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    main_clock,
  input  logic                    reset,
  bus_transfer_ctrl_if.slave      bus
`ifdef XFER_COUNT_EN
  ,
  output logic [7:0]              xfer_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [SEL_W:0]   NREG_L = (SEL_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   q_src [FIFO_DEPTH];
  logic [SEL_W-1:0]   q_dst [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [SEL_W-1:0]   cur_src, cur_dst;
  logic               in_range, accept, push, pop, empty;
  logic               done_q, err_q;
  logic [DATA_W-1:0]  xfer_q;

  // Ready and busy come from registered state only.
  assign empty         = (count == '0);
  assign bus.req_ready = (count != FULL);
  assign bus.busy      = (state != IDLE) || !empty;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.xfer_data = xfer_q;

  // Out-of-range requests are consumed (ready was high) but never queued.
  assign in_range = ({1'b0, bus.req_src} < NREG_L) && ({1'b0, bus.req_dst} < NREG_L);
  assign accept   = bus.req_valid && bus.req_ready;
  assign push     = accept && in_range;

  // Next-state, pop decision and strobe decode. Strobes are dropped while
  // reset is high so an interrupted move never loads its destination.
  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    bus.enable_out = '0;
    bus.load_out   = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (!reset) bus.enable_out = NUM_REGS'(1) << cur_src;
        state_nxt = LOAD;
      end
      LOAD: begin
        if (!reset) bus.load_out = NUM_REGS'(1) << cur_dst;
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge main_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request queue pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are don't-care once count is cleared.
  always_ff @(posedge main_clock) begin
    if (push) begin
      q_src[wr_ptr] <= bus.req_src;
      q_dst[wr_ptr] <= bus.req_dst;
    end
  end

  // Current move, loaded from the queue head on each pop.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      cur_src <= '0;
      cur_dst <= '0;
    end else if (pop) begin
      cur_src <= q_src[rd_ptr];
      cur_dst <= q_dst[rd_ptr];
    end
  end

  // Completion capture and the done/err pulses.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      xfer_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == LOAD);
      err_q  <= accept && !in_range;
      if (state == LOAD) xfer_q <= bus.bus_in;
    end
  end

`ifdef XFER_COUNT_EN
  // Completed-transfer counter, wraps naturally at 8 bits.
  always_ff @(posedge main_clock) begin
    if (reset)       xfer_count <= '0;
    else if (done_q) xfer_count <= xfer_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Scoreboard bench for bus_transfer_ctrl. Three registers are modelled so
// that select value 3 is out of range and the error path is reachable.
module tb_bus_transfer_ctrl;
  localparam int NR = 3;
  localparam int SW = 2;
  localparam int DW = 4;

  logic main_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 main_clock = ~main_clock;

  bus_transfer_ctrl_if #(.NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW)) bif();

`ifdef XFER_COUNT_EN
  logic [7:0] xfer_count;
`endif

  bus_transfer_ctrl #(.NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .main_clock (main_clock),
    .reset      (reset),
    .bus        (bif)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  // Register bank model: enable latches q onto the shared bus, load_enable takes the bus.
  logic [DW-1:0] regs [NR] = '{4'h5, 4'hA, 4'h3};
  logic [DW-1:0] bus_val   = '0;
  assign bif.bus_in = bus_val;
  always @(posedge main_clock) begin
    for (int i = 0; i < NR; i++) begin
      if (bif.enable_out[i]) bus_val <= regs[i];
      if (bif.load_out[i])   regs[i] <= bus_val;
    end
  end

  int cyc = 0;
  always @(posedge main_clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sh [NR];
  logic [DW-1:0] sh_save [NR];
  logic [DW-1:0] exp_data [$];
  logic [SW-1:0] exp_src [$];
  logic [SW-1:0] exp_dst [$];
  int            done_cyc [$];
  int            err_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe, done or err.
  always @(negedge main_clock) begin
    if (!reset) begin
      if (bif.enable_out != '0 || bif.load_out != '0)
        check("strobe_onehot_excl",
              32'(!(bif.enable_out != '0 && bif.load_out != '0) &&
                  $onehot0(bif.enable_out) && $onehot0(bif.load_out)), 32'd1);
      if (bif.enable_out != '0) begin
        if (exp_src.size() == 0) fail_evt("enable_out");
        else check("enable_out", 32'(bif.enable_out), 32'(NR'(1) << exp_src.pop_front()));
      end
      if (bif.load_out != '0) begin
        if (exp_dst.size() == 0) fail_evt("load_out");
        else check("load_out", 32'(bif.load_out), 32'(NR'(1) << exp_dst.pop_front()));
      end
      if (bif.done) begin
        done_cyc.push_back(cyc);
        if (exp_data.size() == 0) fail_evt("done");
        else check("xfer_data", 32'(bif.xfer_data), 32'(exp_data.pop_front()));
      end
      if (bif.err) begin
        if (err_pending == 0) fail_evt("err");
        else begin
          err_pending--;
          tests++;
        end
      end
    end
  end

  // Drive at a negedge, wait for ready, record expectations at the accepting edge.
  task automatic send(input logic [SW-1:0] s, input logic [SW-1:0] d, output int stalls);
    stalls = 0;
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    while (!bif.req_ready && stalls < 50) begin
      @(negedge main_clock);
      stalls++;
    end
    if (!bif.req_ready) begin
      fail_evt("req_ready_timeout");
      bif.req_valid = 1'b0;
      return;
    end
    @(posedge main_clock);
    if (int'(s) < NR && int'(d) < NR) begin
      exp_src.push_back(s);
      exp_dst.push_back(d);
      exp_data.push_back(sh[s]);
      sh[d] = sh[s];
    end else begin
      err_pending++;
    end
    @(negedge main_clock);
  endtask

  task automatic wait_quiet();
    int n = 0;
    bif.req_valid = 1'b0;
    while ((bif.busy || exp_data.size() != 0 || err_pending != 0) && n < 200) begin
      @(negedge main_clock);
      n++;
    end
    if (n >= 200) fail_evt("drain_timeout");
    @(negedge main_clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    sh[0] = 4'h5; sh[1] = 4'hA; sh[2] = 4'h3;
    bif.req_valid = 1'b0;
    bif.req_src   = '0;
    bif.req_dst   = '0;

    // Reset state
    repeat (3) @(negedge main_clock);
    check("rst_ready", 32'(bif.req_ready), 32'd1);
    check("rst_busy",  32'(bif.busy), 32'd0);
    check("rst_done",  32'(bif.done), 32'd0);
    check("rst_err",   32'(bif.err), 32'd0);
    check("rst_strobes", 32'({bif.enable_out, bif.load_out}), 32'd0);
    check("rst_xfer",  32'(bif.xfer_data), 32'd0);
    reset = 1'b0;
    @(negedge main_clock);

    // 1: single move reg1 -> reg2, latency N+1 / N+2 / N+3
    send(2'd1, 2'd2, st);
    bif.req_valid = 1'b0;
    check("t1_en_cycN", 32'(bif.enable_out), 32'd0);
    @(negedge main_clock);
    check("t1_en_cycN1", 32'(bif.enable_out), 32'b010);
    @(negedge main_clock);
    check("t1_ld_cycN2", 32'(bif.load_out), 32'b100);
    @(negedge main_clock);
    check("t1_done_cycN3", 32'(bif.done), 32'd1);
    check("t1_xfer", 32'(bif.xfer_data), 32'hA);
    wait_quiet();
    check("t1_reg2", 32'(regs[2]), 32'hA);

    // 2: four back-to-back moves; regs {5,A,A} -> {A,5,A}
    done_cyc.delete();
    send(2'd0, 2'd1, st); check("t2_stall0", 32'(st), 32'd0);
    send(2'd2, 2'd0, st); check("t2_stall1", 32'(st), 32'd0);
    send(2'd1, 2'd2, st); check("t2_stall2", 32'(st), 32'd0);
    send(2'd0, 2'd2, st); check("t2_stall3", 32'(st), 32'd0);
    wait_quiet();
    check("t2_ndone", 32'(done_cyc.size()), 32'd4);
    for (int i = 1; i < done_cyc.size(); i++)
      check("t2_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);
    check("t2_reg0", 32'(regs[0]), 32'hA);
    check("t2_reg1", 32'(regs[1]), 32'h5);
    check("t2_reg2", 32'(regs[2]), 32'hA);

    // 3: eight consecutive requests; the queue fills on the 7th, the 8th waits one cycle
    for (int i = 0; i < 8; i++) begin
      send(SW'(i % 3), SW'((i + 1) % 3), st);
      check("t3_stalls", 32'(st), (i == 7) ? 32'd1 : 32'd0);
    end
    wait_quiet();

    // 4: out-of-range requests produce err one cycle later and nothing else
    send(2'd3, 2'd0, st);
    bif.req_valid = 1'b0;
    check("t4_err", 32'(bif.err), 32'd1);
    check("t4_busy", 32'(bif.busy), 32'd0);
    @(negedge main_clock);
    check("t4_err_pulse", 32'(bif.err), 32'd0);
    check("t4_strobes", 32'({bif.enable_out, bif.load_out}), 32'd0);
    send(2'd1, 2'd3, st);
    bif.req_valid = 1'b0;
    check("t4_err_dst", 32'(bif.err), 32'd1);
    wait_quiet();

    // 5: reset during LOAD of move 0->2 with two moves still queued
    for (int i = 0; i < NR; i++) sh_save[i] = sh[i];
    send(2'd0, 2'd2, st);
    send(2'd1, 2'd0, st);
    send(2'd2, 2'd1, st);
    bif.req_valid = 1'b0;
    check("t5_in_load", 32'(bif.load_out), 32'b100);
    #1 reset = 1'b1;
    @(posedge main_clock);
    #1;
    exp_src.delete(); exp_dst.delete(); exp_data.delete();
    err_pending = 0;
    @(negedge main_clock);
    check("t5_strobes", 32'({bif.enable_out, bif.load_out}), 32'd0);
    check("t5_busy", 32'(bif.busy), 32'd0);
    check("t5_ready", 32'(bif.req_ready), 32'd1);
    check("t5_done", 32'(bif.done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) sh[i] = sh_save[i];
    check("t5_reg2_kept", 32'(regs[2]), 32'(sh_save[2]));
    repeat (3) @(negedge main_clock);
    check("t5_idle_after", 32'(bif.busy), 32'd0);

`ifdef XFER_COUNT_EN
    // 6: 257 moves wrap the 8-bit counter to 1
    check("t6_cnt_start", 32'(xfer_count), 32'd0);
    for (int i = 0; i < 257; i++) send(2'd0, 2'd1, st);
    wait_quiet();
    check("t6_xfer_count", 32'(xfer_count), 32'd1);
`endif

    check("sb_drained", 32'(exp_data.size() + exp_src.size() + exp_dst.size() + err_pending), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
